// File: rtl/core_dbg_hart_ctrl.sv
// Debug-mode hart controller: per-hart RUNNING/HALTED/RESUME sequencing with
// dcsr/dpc/cause tracking, plus a one-cycle-latency abstract register port.
module core_dbg_hart_ctrl #(
    parameter int NHARTS     = 2,
    parameter int XLEN       = 32,
    parameter int RESET_HALT = 0,
    localparam int AW        = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NHARTS-1:0]        ebreak_i,
    input  logic [NHARTS-1:0]        trap_i,
    input  logic [NHARTS-1:0]        inst_valid_wb_i,
    input  logic [NHARTS*XLEN-1:0]   cinst_pc_i,
    input  logic [NHARTS*XLEN-1:0]   pc_if_jump_i,
    input  logic [NHARTS-1:0]        haltreq_i,
    input  logic [NHARTS-1:0]        resumereq_i,
    output logic [NHARTS-1:0]        running_o,
    output logic [NHARTS-1:0]        halted_o,
    output logic [NHARTS-1:0]        resumeack_o,
    output logic [NHARTS-1:0]        dbg_ret_o,
    output logic [NHARTS-1:0]        dont_trap_o,
    input  logic                     ar_en_i,
    input  logic                     ar_wr_i,
    input  logic [AW-1:0]            ar_hart_i,
    input  logic [15:0]              ar_ad_i,
    input  logic [XLEN-1:0]          ar_wdata_i,
    output logic [XLEN-1:0]          ar_rdata_o,
    output logic                     ar_done_o,
    output logic                     ar_err_o
);
    // state   | meaning
    // RUNNING | hart executing normally, halt conditions monitored
    // HALTED  | hart parked in debug mode, abstract access permitted
    // RESUME  | resume acknowledged, waiting for resumereq_i to drop
    typedef enum logic [1:0] {
        ST_RUNNING = 2'd0,
        ST_HALTED  = 2'd1,
        ST_RESUME  = 2'd2
    } state_e;

    localparam logic [15:0] AD_DCSR       = 16'h07b0;
    localparam logic [15:0] AD_DPC        = 16'h07b1;
    localparam logic [2:0]  CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0]  CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0]  CAUSE_STEP    = 3'd4;
    localparam logic [2:0]  CAUSE_RSTHALT = 3'd5;

    state_e            state_q [NHARTS];
    state_e            state_d [NHARTS];
    logic [2:0]        cause_q [NHARTS];
    logic [2:0]        cause_d [NHARTS];
    logic [XLEN-1:0]   dpc_q   [NHARTS];
    logic [XLEN-1:0]   dpc_d   [NHARTS];
    logic [XLEN-1:0]   dcsr_rd [NHARTS];

    logic [NHARTS-1:0] ebreakm_q, ebreakm_d;
    logic [NHARTS-1:0] stepie_q, stepie_d;
    logic [NHARTS-1:0] stopcount_q, stopcount_d;
    logic [NHARTS-1:0] stoptime_q, stoptime_d;
    logic [NHARTS-1:0] step_q, step_d;
    logic [NHARTS-1:0] dbg_ret_q, dbg_ret_d;

    logic              ar_done_q, ar_done_d;
    logic              ar_err_q, ar_err_d;
    logic [XLEN-1:0]   ar_rdata_q, ar_rdata_d;

    logic [NHARTS-1:0] is_running, is_halted, is_resume;
    logic [NHARTS-1:0] brk, step_or_req, halt_now;
    logic [NHARTS-1:0] hart_hit, wr_sel;
    logic              hart_ok, tgt_halted, ad_dcsr, ad_dpc, ar_bad, ar_ok;
    logic [XLEN-1:0]   tgt_dcsr, tgt_dpc;

    always_comb begin
        is_running = '0;
        is_halted  = '0;
        is_resume  = '0;
        for (int h = 0; h < NHARTS; h++) begin
            is_running[h] = (state_q[h] == ST_RUNNING);
            is_halted[h]  = (state_q[h] == ST_HALTED) || (state_q[h] == ST_RESUME);
            is_resume[h]  = (state_q[h] == ST_RESUME);
            dcsr_rd[h]    = XLEN'({4'd4, 12'd0, ebreakm_q[h], 3'd0, stepie_q[h],
                                   stopcount_q[h], stoptime_q[h], cause_q[h], 3'd0,
                                   step_q[h], 2'd3});
        end
    end

    assign brk         = ebreak_i & ebreakm_q;
    assign step_or_req = step_q | haltreq_i;
    assign halt_now    = brk | (step_or_req & (trap_i | inst_valid_wb_i));

    assign running_o   = is_running;
    assign halted_o    = is_halted;
    assign resumeack_o = is_resume;
    assign dbg_ret_o   = dbg_ret_q;
    assign dont_trap_o = is_running & ((step_or_req & inst_valid_wb_i) | brk);

    // Hart select by match rather than indexing, so out-of-range ids fall out as errors.
    always_comb begin
        hart_hit   = '0;
        hart_ok    = 1'b0;
        tgt_halted = 1'b0;
        tgt_dcsr   = '0;
        tgt_dpc    = '0;
        for (int h = 0; h < NHARTS; h++) begin
            if (ar_hart_i == AW'(h)) begin
                hart_hit[h] = 1'b1;
                hart_ok     = 1'b1;
                tgt_halted  = is_halted[h];
                tgt_dcsr    = dcsr_rd[h];
                tgt_dpc     = dpc_q[h];
            end
        end
    end

    assign ad_dcsr = (ar_ad_i == AD_DCSR);
    assign ad_dpc  = (ar_ad_i == AD_DPC);
    assign ar_bad  = !(hart_ok && tgt_halted && (ad_dcsr || ad_dpc));
    assign ar_ok   = ar_en_i && !ar_bad;
    assign wr_sel  = hart_hit & {NHARTS{ar_ok && ar_wr_i}};

    always_comb begin
        ar_done_d  = ar_en_i;
        ar_err_d   = ar_en_i && ar_bad;
        ar_rdata_d = '0;
        if (ar_ok) begin
            ar_rdata_d = ad_dcsr ? tgt_dcsr : tgt_dpc;
        end
    end

    always_comb begin
        ebreakm_d   = ebreakm_q;
        stepie_d    = stepie_q;
        stopcount_d = stopcount_q;
        stoptime_d  = stoptime_q;
        step_d      = step_q;
        dbg_ret_d   = '0;
        for (int h = 0; h < NHARTS; h++) begin
            state_d[h] = state_q[h];
            cause_d[h] = cause_q[h];
            dpc_d[h]   = dpc_q[h];
            case (state_q[h])
                ST_RUNNING: begin
                    if (brk[h] || (step_or_req[h] && inst_valid_wb_i[h])) begin
                        dpc_d[h] = cinst_pc_i[h*XLEN +: XLEN];
                    end else if (step_or_req[h] && trap_i[h]) begin
                        dpc_d[h] = pc_if_jump_i[h*XLEN +: XLEN];
                    end else if (haltreq_i[h]) begin
                        dpc_d[h] = cinst_pc_i[h*XLEN +: XLEN];
                    end
                    if (halt_now[h]) begin
                        state_d[h] = ST_HALTED;
                        if (brk[h]) begin
                            cause_d[h] = CAUSE_EBREAK;
                        end else if (haltreq_i[h]) begin
                            cause_d[h] = CAUSE_HALTREQ;
                        end else begin
                            cause_d[h] = CAUSE_STEP;
                        end
                    end
                end
                ST_HALTED: begin
                    if (resumereq_i[h]) begin
                        state_d[h] = ST_RESUME;
                    end
                end
                ST_RESUME: begin
                    if (!resumereq_i[h]) begin
                        state_d[h]   = ST_RUNNING;
                        dbg_ret_d[h] = 1'b1;
                    end
                end
                default: state_d[h] = ST_RUNNING;
            endcase
            if (wr_sel[h] && ad_dcsr) begin
                ebreakm_d[h]   = ar_wdata_i[15];
                stepie_d[h]    = ar_wdata_i[11];
                stopcount_d[h] = ar_wdata_i[10];
                stoptime_d[h]  = ar_wdata_i[9];
                step_d[h]      = ar_wdata_i[2];
            end
            if (wr_sel[h] && ad_dpc) begin
                dpc_d[h] = ar_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int h = 0; h < NHARTS; h++) begin
                if (RESET_HALT != 0) begin
                    state_q[h] <= ST_HALTED;
                    cause_q[h] <= CAUSE_RSTHALT;
                end else begin
                    state_q[h] <= ST_RUNNING;
                    cause_q[h] <= 3'd0;
                end
                dpc_q[h] <= '0;
            end
            ebreakm_q   <= '0;
            stepie_q    <= '0;
            stopcount_q <= '0;
            stoptime_q  <= '0;
            step_q      <= '0;
            dbg_ret_q   <= '0;
            ar_done_q   <= 1'b0;
            ar_err_q    <= 1'b0;
            ar_rdata_q  <= '0;
        end else begin
            for (int h = 0; h < NHARTS; h++) begin
                state_q[h] <= state_d[h];
                cause_q[h] <= cause_d[h];
                dpc_q[h]   <= dpc_d[h];
            end
            ebreakm_q   <= ebreakm_d;
            stepie_q    <= stepie_d;
            stopcount_q <= stopcount_d;
            stoptime_q  <= stoptime_d;
            step_q      <= step_d;
            dbg_ret_q   <= dbg_ret_d;
            ar_done_q   <= ar_done_d;
            ar_err_q    <= ar_err_d;
            ar_rdata_q  <= ar_rdata_d;
        end
    end

    assign ar_done_o  = ar_done_q;
    assign ar_err_o   = ar_err_q;
    assign ar_rdata_o = ar_rdata_q;

endmodule
